pll_lock_mon: RTL and testbench

Synthesizable lock monitor and divider for the 8x clock-multiplication path. It runs on the multiplied clock and samples the asynchronous reference clock, measuring how many fast cycles fall in each reference period. It declares lock after a run of in-tolerance periods and regenerates a divided-by-MULT clock realigned to the reference, so downstream logic can confirm that the multiplier output matches its input.

---
 rtl/pll_mon_pkg.sv | 18 +
 rtl/sync_edge.sv | 27 ++
 rtl/pll_lock_mon.sv | 129 ++++++++++++
 tb/tb_pll_lock_mon.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor: FSM state encoding,
// synchronizer depth and the period tolerance test.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } pll_state_t;

  localparam int SYNC_DEPTH = 2;

  // Written as two one-sided compares so an unsigned period never underflows.
  function automatic logic period_good(input int period, input int mult, input int tol);
    return ((period + tol) >= mult) && (period <= (mult + tol));
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector; the
// pulse appears three clk edges after the asynchronous input rises.
module sync_edge
  import pll_mon_pkg::*;
(
  input  logic clk,
  input  logic RST,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
      prev_q <= sync_q[SYNC_DEPTH-1];
      rise   <= sync_q[SYNC_DEPTH-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/pll_lock_mon.sv
// Lock monitor for the multiplied clock: measures reference periods in fast
// cycles, tracks lock with an IDLE/ACQ/LOCK FSM and regenerates a divided clock.
module pll_lock_mon
  import pll_mon_pkg::*;
#(
  parameter int MULT     = 8,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             ref_clk,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             err,
  output logic             div_clk,
  output pll_state_t       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * MULT);
  localparam int               PH_W    = $clog2(MULT);
  localparam int               GC_W    = $clog2(LOCK_CNT + 1);

  logic             ref_rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic             good;
  logic [PH_W-1:0]  ph;
  logic [PH_W-1:0]  ph_next;
  logic [GC_W-1:0]  good_cnt;
  pll_state_t       state;

  sync_edge u_ref_sync (
    .clk      (clk),
    .RST      (RST),
    .async_in (ref_clk),
    .rise     (ref_rise)
  );

  // A reference edge arriving on the saturation cycle still counts as an edge.
  assign cnt_inc   = cnt + CNT_W'(1);
  assign timeout   = (cnt == CNT_MAX) && !ref_rise;
  assign good      = period_good(int'(cnt_inc), MULT, TOL);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt    <= '0;
      period <= '0;
    end else if (ref_rise) begin
      cnt    <= '0;
      period <= cnt_inc;
    end else if (cnt != CNT_MAX) begin
      cnt    <= cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      good_cnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_rise) begin
            state    <= ACQ;
            good_cnt <= '0;
          end
        end
        ACQ: begin
          if (timeout) begin
            state    <= IDLE;
            good_cnt <= '0;
          end else if (ref_rise) begin
            if (!good) begin
              good_cnt <= '0;
            end else if (good_cnt == GC_W'(LOCK_CNT - 1)) begin
              state    <= LOCK;
              good_cnt <= GC_W'(LOCK_CNT);
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_cnt + GC_W'(1);
            end
          end
        end
        LOCK: begin
          if (timeout) begin
            state    <= IDLE;
            good_cnt <= '0;
            locked   <= 1'b0;
            err      <= 1'b1;
          end else if (ref_rise && !good) begin
            state    <= ACQ;
            good_cnt <= '0;
            locked   <= 1'b0;
            err      <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

  // div_clk is driven from the next phase so it goes high the cycle after ref_rise.
  always_comb begin
    ph_next = ph + PH_W'(1);
    if (ref_rise || (ph == PH_W'(MULT - 1))) ph_next = '0;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      ph      <= '0;
      div_clk <= 1'b0;
    end else begin
      ph      <= ph_next;
      div_clk <= (ph_next < PH_W'(MULT / 2));
    end
  end

endmodule

// File: tb/tb_pll_lock_mon.sv
// Bench for pll_lock_mon: scenario table with hand-derived expectations plus
// randomized reference periods checked every cycle against an event-level model.
module tb_pll_lock_mon;
  import pll_mon_pkg::*;

  localparam int MULT     = 8;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 6;
  localparam int SAT_P    = 2 * MULT + 1;

  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic             ref_clk = 1'b0;
  logic [CNT_W-1:0] period;
  logic             locked;
  logic             err;
  logic             div_clk;
  pll_state_t       state_dbg;

  int vectors = 0;
  int miscompares = 0;

  pll_lock_mon #(.MULT(MULT), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .RST       (RST),
    .ref_clk   (ref_clk),
    .period    (period),
    .locked    (locked),
    .err       (err),
    .div_clk   (div_clk),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model, expressed in terms of edge timestamps.
  int  n = 0;
  bit  h[4];
  int  last_rise = 0;
  int  ph_origin = 0;
  int  run = 0;
  bit  acq = 0;
  bit  m_locked = 0;
  bit  m_err = 0;
  bit  m_div = 0;
  int  m_period = 0;
  bit  err_seen = 0;
  int  since_edge = 0;
  bit  had_edge = 0;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, n, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit rv);
    bit rise;
    int p;
    n++;
    if (r) begin
      for (int i = 0; i < 4; i++) h[i] = 1'b0;
      last_rise = n; ph_origin = n;
      acq = 0; run = 0; m_locked = 0; m_err = 0; m_period = 0; m_div = 0;
      return;
    end
    // The edge seen now was sampled three edges ago and was low one edge before that.
    rise = h[2] && !h[3];
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = rv;
    m_err = 0;
    if (rise) begin
      p = (n - last_rise > SAT_P) ? SAT_P : n - last_rise;
      m_period = p;
      if (!acq) begin
        acq = 1; run = 0;
      end else if (p >= MULT - TOL && p <= MULT + TOL) begin
        run++;
        if (run >= LOCK_CNT) m_locked = 1;
      end else begin
        if (m_locked) m_err = 1;
        m_locked = 0; run = 0;
      end
      last_rise = n; ph_origin = n;
    end else if (acq && (n - last_rise >= SAT_P)) begin
      if (m_locked) m_err = 1;
      m_locked = 0; acq = 0; run = 0;
    end
    m_div = ((n - ph_origin) % MULT) < (MULT / 2);
  endtask

  task automatic tick(input bit r, input bit rv);
    @(negedge clk);
    RST = r;
    ref_clk = rv;
    @(posedge clk);
    #1;
    model_step(r, rv);
    check("cycle_model", {period, locked, err, div_clk},
          {CNT_W'(m_period), m_locked, m_err, m_div});
    err_seen |= err;
  endtask

  typedef struct {
    int rst_cycles;
    int ivl;
    int exp_period;
    bit chk_p;
    bit exp_locked;
    bit exp_err;
  } row_t;

  row_t rows[$];

  task automatic run_row(input row_t rw);
    if (rw.rst_cycles > 0) begin
      err_seen = 0;
      for (int i = 0; i < rw.rst_cycles; i++) begin
        tick(1'b1, 1'b0);
        check("rst_outputs", {period, locked, err, div_clk}, 0);
        check("rst_state", int'(state_dbg), int'(IDLE));
      end
      since_edge = 0;
      had_edge = 0;
    end
    for (int k = since_edge; k < rw.ivl; k++) tick(1'b0, had_edge && k < 3);
    for (int k = 0; k < 5; k++) tick(1'b0, k < 3);
    since_edge = 5;
    had_edge = 1;
    if (rw.chk_p) check("row_period", period, rw.exp_period);
    check("row_locked", locked, rw.exp_locked);
    check("row_err", err_seen, rw.exp_err);
    err_seen = 0;
  endtask

  initial begin
    // Steady 8-cycle reference: lock on the 5th edge.
    rows.push_back('{3, 6, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++) rows.push_back('{0, 8, 8, 1, 0, 0});
    rows.push_back('{0, 8, 8, 1, 1, 0});
    rows.push_back('{0, 8, 8, 1, 1, 0});
    // One stretched period drops lock, four good periods relock.
    rows.push_back('{0, 10, 10, 1, 0, 1});
    for (int i = 0; i < 3; i++) rows.push_back('{0, 8, 8, 1, 0, 0});
    rows.push_back('{0, 8, 8, 1, 1, 0});
    // Jitter within tolerance keeps lock.
    rows.push_back('{0, 9, 9, 1, 1, 0});
    rows.push_back('{0, 7, 7, 1, 1, 0});
    rows.push_back('{0, 9, 9, 1, 1, 0});
    rows.push_back('{0, 7, 7, 1, 1, 0});
    // Stopped reference times out, restart relocks after five edges.
    rows.push_back('{0, 30, SAT_P, 1, 0, 1});
    for (int i = 0; i < 3; i++) rows.push_back('{0, 8, 8, 1, 0, 0});
    rows.push_back('{0, 8, 8, 1, 1, 0});
    // Reset while locked: no err, then normal relock.
    rows.push_back('{1, 6, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++) rows.push_back('{0, 8, 8, 1, 0, 0});
    rows.push_back('{0, 8, 8, 1, 1, 0});

    foreach (rows[i]) run_row(rows[i]);

    // Randomized periods, high widths and occasional resets.
    for (int e = 0; e < 150; e++) begin
      int ivl;
      int hw;
      if ($urandom_range(0, 40) == 0) tick(1'b1, 1'b0);
      ivl = ($urandom_range(0, 9) < 7) ? int'($urandom_range(MULT - TOL, MULT + TOL))
                                       : int'($urandom_range(5, 24));
      hw = int'($urandom_range(1, ivl - 1));
      for (int k = 0; k < ivl; k++) tick(1'b0, k < hw);
    end
    for (int k = 0; k < 30; k++) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
